// File: rtl/spi_slave_rx_mw.sv
// ============================================================================
// spi_slave_rx_mw : parametrised single/dual/quad SPI slave receive shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_slave_rx_mw #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int RESET_LEN  = 31,
    parameter bit MSB_FIRST  = 1
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic [3:0]            sdi,
    input  logic [1:0]            mode_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic                  len_upd_i,
    input  logic                  cont_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic [DATA_WIDTH-1:0] data_last_o,
    output logic                  busy_o,
    output logic [15:0]           word_cnt_o,
    output logic                  len_err_o
);

    localparam logic [CNT_WIDTH-1:0] c_MAX_SINGLE = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_MAX_DUAL   = CNT_WIDTH'(DATA_WIDTH / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] c_MAX_QUAD   = CNT_WIDTH'(DATA_WIDTH / 4 - 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_last_q, data_last_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  tgt_q, tgt_d;
    logic                  running_q, running_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic                  len_err_q, len_err_d;

    logic [1:0]            w_lsh;
    logic [CNT_WIDTH-1:0]  w_max;
    logic [DATA_WIDTH-1:0] w_nxt;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_done;

    // Lane count is 1 << w_lsh; the reserved mode 11 falls back to single.
    always_comb begin
        w_lsh = 2'd0;
        w_max = c_MAX_SINGLE;
        case (mode_i)
            2'b01: begin w_lsh = 2'd1; w_max = c_MAX_DUAL; end
            2'b10: begin w_lsh = 2'd2; w_max = c_MAX_QUAD; end
            default: begin w_lsh = 2'd0; w_max = c_MAX_SINGLE; end
        endcase
    end

    assign w_done = running_q && (cnt_q >= tgt_q);

    generate
        if (MSB_FIRST) begin : g_msb
            always_comb begin
                w_nxt = {shreg_q[DATA_WIDTH-2:0], sdi[0]};
                case (w_lsh)
                    2'd1:    w_nxt = {shreg_q[DATA_WIDTH-3:0], sdi[1:0]};
                    2'd2:    w_nxt = {shreg_q[DATA_WIDTH-5:0], sdi[3:0]};
                    default: w_nxt = {shreg_q[DATA_WIDTH-2:0], sdi[0]};
                endcase
            end
            assign w_data = w_nxt;
        end else begin : g_lsb
            logic [31:0] w_used;
            always_comb begin
                w_nxt = {sdi[0], shreg_q[DATA_WIDTH-1:1]};
                case (w_lsh)
                    2'd1:    w_nxt = {sdi[1:0], shreg_q[DATA_WIDTH-1:2]};
                    2'd2:    w_nxt = {sdi[3:0], shreg_q[DATA_WIDTH-1:4]};
                    default: w_nxt = {sdi[0], shreg_q[DATA_WIDTH-1:1]};
                endcase
            end
            // Bits received so far sit at the top of the register; slide them down.
            assign w_used = (32'(cnt_q) + 32'd1) << w_lsh;
            assign w_data = (w_used < 32'(DATA_WIDTH))
                          ? (w_nxt >> (32'(DATA_WIDTH) - w_used)) : w_nxt;
        end
    endgenerate

    always_comb begin
        shreg_d     = shreg_q;
        data_last_d = data_last_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        running_d   = running_q;
        word_cnt_d  = word_cnt_q;
        len_err_d   = len_err_q;

        if (w_done) begin
            data_last_d = w_data;
            shreg_d     = '0;
            cnt_d       = '0;
            word_cnt_d  = word_cnt_q + 16'd1;
            running_d   = cont_i;
        end else if (running_q) begin
            shreg_d = w_nxt;
            cnt_d   = cnt_q + 1'b1;
        end

        // A length update overrides the stop decision of a completing word.
        if (len_upd_i) begin
            running_d = 1'b1;
            if (len_i > w_max) begin
                tgt_d     = w_max;
                len_err_d = 1'b1;
            end else begin
                tgt_d = len_i;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            data_last_q <= '0;
            cnt_q       <= '0;
            tgt_q       <= CNT_WIDTH'(RESET_LEN);
            running_q   <= 1'b1;
            word_cnt_q  <= '0;
            len_err_q   <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            data_last_q <= data_last_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            running_q   <= running_d;
            word_cnt_q  <= word_cnt_d;
            len_err_q   <= len_err_d;
        end
    end

    assign data_o       = running_q ? w_data : shreg_q;
    assign data_valid_o = w_done;
    assign data_last_o  = data_last_q;
    assign busy_o       = running_q;
    assign word_cnt_o   = word_cnt_q;
    assign len_err_o    = len_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx_mw.sv
// ============================================================================
// tb_spi_slave_rx_mw : directed scoreboard bench for spi_slave_rx_mw
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_rx_mw;

    logic        sclk;
    logic        rst_n;
    logic [3:0]  sdi;
    logic [1:0]  mode_i;
    logic [7:0]  len_i;
    logic        len_upd_i;
    logic        cont_i;

    logic [31:0] data_o, data_last_o, l_data_o, l_data_last_o;
    logic        data_valid_o, busy_o, len_err_o;
    logic        l_data_valid_o, l_busy_o, l_len_err_o;
    logic [15:0] word_cnt_o, l_word_cnt_o;

    int tests = 0;
    int fails = 0;
    int exp_wc = 0;
    logic [31:0] sb[$];

    spi_slave_rx_mw #(.DATA_WIDTH(32), .CNT_WIDTH(8), .RESET_LEN(31), .MSB_FIRST(1)) u_dut (
        .sclk(sclk), .rst_n(rst_n), .sdi(sdi), .mode_i(mode_i), .len_i(len_i),
        .len_upd_i(len_upd_i), .cont_i(cont_i), .data_o(data_o),
        .data_valid_o(data_valid_o), .data_last_o(data_last_o), .busy_o(busy_o),
        .word_cnt_o(word_cnt_o), .len_err_o(len_err_o)
    );

    spi_slave_rx_mw #(.DATA_WIDTH(32), .CNT_WIDTH(8), .RESET_LEN(31), .MSB_FIRST(0)) u_lsb (
        .sclk(sclk), .rst_n(rst_n), .sdi(sdi), .mode_i(mode_i), .len_i(len_i),
        .len_upd_i(len_upd_i), .cont_i(cont_i), .data_o(l_data_o),
        .data_valid_o(l_data_valid_o), .data_last_o(l_data_last_o), .busy_o(l_busy_o),
        .word_cnt_o(l_word_cnt_o), .len_err_o(l_len_err_o)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // Any valid pulse must match the oldest outstanding expected word.
    always @(negedge sclk) begin
        if (rst_n && data_valid_o) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_valid obs=%h exp=none", data_o);
            end
            if (sb.size() != 0) begin
                logic [31:0] e;
                e = sb.pop_front();
                tests++;
                assert (data_o === e) else begin
                    fails++;
                    $error("FAIL word obs=%h exp=%h", data_o, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_wc = 0;
    endtask

    // Shift one word in, first chunk first; the expectation is queued just
    // before the final beat so an early valid is caught as unexpected.
    task automatic word(input logic [31:0] w, input int nbeats, input int lsh,
                        input bit upd_last, input logic [7:0] len_last,
                        input bit do_lsb, input logic [31:0] lsb_exp);
        int L;
        logic [31:0] msk;
        L   = 1 << lsh;
        msk = (32'd1 << L) - 32'd1;
        for (int i = 0; i < nbeats; i++) begin
            sdi = 4'((w >> ((nbeats - 1 - i) * L)) & msk);
            if (i == nbeats - 1) begin
                sb.push_back(w);
                if (upd_last) begin
                    len_upd_i = 1'b1;
                    len_i     = len_last;
                end
                if (do_lsb) begin
                    @(negedge sclk);
                    chk("lsb_valid", 32'(l_data_valid_o), 32'd1);
                    chk("lsb_data", l_data_o, lsb_exp);
                end
            end
            step();
            len_upd_i = 1'b0;
        end
        exp_wc++;
    endtask

    task automatic idle_upd(input logic [7:0] len);
        len_i     = len;
        len_upd_i = 1'b1;
        step();
        len_upd_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sdi = '0; mode_i = 2'b00; len_i = '0; len_upd_i = 1'b0; cont_i = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_wcnt", 32'(word_cnt_o), 32'd0);
        chk("rst_err", 32'(len_err_o), 32'd0);
        chk("rst_last", data_last_o, 32'd0);
        chk("rst_valid", 32'(data_valid_o), 32'd0);
        rst_n = 1'b1;

        // Quad word, length update on the first beat.
        mode_i = 2'b10; cont_i = 1'b0; len_i = 8'd7; len_upd_i = 1'b1;
        word(32'hDEADBEEF, 8, 2, 1'b0, 8'd0, 1'b0, 32'd0);
        chk("q_last", data_last_o, 32'hDEADBEEF);
        chk("q_wcnt", 32'(word_cnt_o), 32'd1);
        chk("q_busy", 32'(busy_o), 32'd0);
        chk("idle_valid", 32'(data_valid_o), 32'd0);

        // Single mode, reset length, continuous two words.
        do_reset();
        mode_i = 2'b00; cont_i = 1'b1;
        word(32'hA5A50F0F, 32, 0, 1'b0, 8'd0, 1'b0, 32'd0);
        word(32'hFFFFFFFF, 32, 0, 1'b0, 8'd0, 1'b0, 32'd0);
        chk("s_busy", 32'(busy_o), 32'd1);
        chk("s_wcnt", 32'(word_cnt_o), 32'd2);
        chk("s_last", data_last_o, 32'hFFFFFFFF);

        // LSB-first instance right-justifies an 8-bit word.
        do_reset();
        mode_i = 2'b00; cont_i = 1'b0; len_i = 8'd7; len_upd_i = 1'b1;
        word(32'h00000080, 8, 0, 1'b0, 8'd0, 1'b1, 32'h00000001);
        chk("lsb_last", l_data_last_o, 32'h00000001);
        chk("lsb_busy", 32'(l_busy_o), 32'd0);

        // Clamped length request in quad mode.
        mode_i = 2'b10;
        idle_upd(8'd15);
        chk("clamp_err", 32'(len_err_o), 32'd1);
        word(32'h12345678, 8, 2, 1'b0, 8'd0, 1'b0, 32'd0);
        chk("clamp_busy", 32'(busy_o), 32'd0);
        idle_upd(8'd7);
        word(32'h9ABCDEF0, 8, 2, 1'b0, 8'd0, 1'b0, 32'd0);
        chk("err_sticky", 32'(len_err_o), 32'd1);
        chk("clamp_wcnt", 32'(word_cnt_o), 32'(exp_wc));

        // Length update coincident with completion.
        idle_upd(8'd7);
        word(32'h13579BDF, 8, 2, 1'b1, 8'd3, 1'b0, 32'd0);
        chk("coinc_busy", 32'(busy_o), 32'd1);
        chk("coinc_last", data_last_o, 32'h13579BDF);
        word(32'h0000ABCD, 4, 2, 1'b0, 8'd0, 1'b0, 32'd0);
        chk("short_busy", 32'(busy_o), 32'd0);
        chk("short_last", data_last_o, 32'h0000ABCD);
        chk("short_wcnt", 32'(word_cnt_o), 32'(exp_wc));

        // Reset mid-word discards the partial word.
        idle_upd(8'd7);
        for (int i = 0; i < 5; i++) begin
            sdi = 4'(i + 3);
            step();
        end
        rst_n = 1'b0;
        #2;
        chk("mid_wcnt", 32'(word_cnt_o), 32'd0);
        chk("mid_last", data_last_o, 32'd0);
        chk("mid_busy", 32'(busy_o), 32'd1);
        chk("mid_err", 32'(len_err_o), 32'd0);
        chk("mid_valid", 32'(data_valid_o), 32'd0);
        step();
        rst_n = 1'b1;
        exp_wc = 0;
        mode_i = 2'b00; cont_i = 1'b0;
        word(32'h3C5A96E1, 32, 0, 1'b0, 8'd0, 1'b0, 32'd0);
        chk("post_last", data_last_o, 32'h3C5A96E1);
        chk("post_wcnt", 32'(word_cnt_o), 32'd1);

        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
